lsu_wb: RTL and testbench

- Load/store unit sitting directly upstream of the core's Wishbone B4 classic master path.
- Converts one core memory request (address, size, signedness, store data) into a single aligned Wishbone B4 classic cycle.
- Returns one response per request: load data aligned and sign/zero-extended, or an error or misalignment flag.
- Owns cyc/stb sequencing, byte-lane selection, bus timeout and response generation.

---
 rtl/lsu_pkg.sv | 12 +
 rtl/lsu_align.sv | 25 ++
 rtl/lsu_wb.sv | 102 ++++++++++
 tb/tb_lsu_wb.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: size encodings, FSM states and the alignment check shared by the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'd0) || size == 2'd3;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane select plus store replication or load extract/extend for one transfer
module lsu_align
    import lsu_pkg::*;
(
    input  logic        load,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        uns,
    input  logic [31:0] din,
    output logic [3:0]  sel,
    output logic [31:0] dout
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b    = din[{off, 3'b000} +: 8];
        h    = din[{off[1], 4'b0000} +: 16];
        sel  = size == SZ_BYTE ? 4'b0001 << off : size == SZ_HALF ? 4'b0011 << off : 4'hF;
        dout = load ? (size == SZ_BYTE ? {{24{b[7] & ~uns}}, b} :
                       size == SZ_HALF ? {{16{h[15] & ~uns}}, h} : din)
                    : (size == SZ_BYTE ? {4{din[7:0]}} :
                       size == SZ_HALF ? {2{din[15:0]}} : din);
    end
endmodule

// File: rtl/lsu_wb.sv
// lsu_wb: turns one core memory request into a single aligned Wishbone B4 classic cycle
module lsu_wb
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_misaligned_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);
    localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic        we_q, uns_q, err_q, mis_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  st_sel, ld_sel;
    logic [31:0] st_dat, ld_dat;
    logic        bus, tmo, done;

    lsu_align u_st (.load(1'b0), .size(size_q), .off(addr_q[1:0]), .uns(1'b0),
                    .din(wdata_q), .sel(st_sel), .dout(st_dat));
    lsu_align u_ld (.load(1'b1), .size(size_q), .off(addr_q[1:0]), .uns(uns_q),
                    .din(wbm_dat_i), .sel(ld_sel), .dout(ld_dat));

    assign bus  = state == BUS;
    // cnt counts completed BUS cycles, so this fires in the TIMEOUT_CYCLES-th strobe cycle
    assign tmo  = TIMEOUT_CYCLES != 0 && 32'(cnt) + 32'd1 == 32'(TIMEOUT_CYCLES);
    assign done = wbm_ack_i || wbm_err_i || tmo;

    always_comb begin
        state_n = state == IDLE ? (req_valid_i ? (misaligned(req_size_i, req_addr_i[1:0]) ? RESP : BUS) : IDLE)
                : state == BUS  ? (done ? RESP : BUS) : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_valid_i) begin
                we_q    <= req_we_i;
                uns_q   <= req_unsigned_i;
                size_q  <= req_size_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                mis_q   <= misaligned(req_size_i, req_addr_i[1:0]);
                err_q   <= 1'b0;
                rdata_q <= '0;
                cnt     <= '0;
            end
            if (bus) begin
                cnt <= cnt + 1'b1;
                if (done) begin
                    err_q   <= wbm_err_i || !wbm_ack_i;
                    rdata_q <= wbm_ack_i && !wbm_err_i && !we_q ? ld_dat : '0;
                end
            end
        end
    end

    assign req_ready_o      = state == IDLE;
    assign rsp_valid_o      = state == RESP;
    assign rsp_rdata_o      = rsp_valid_o ? rdata_q : '0;
    assign rsp_err_o        = rsp_valid_o & err_q;
    assign rsp_misaligned_o = rsp_valid_o & mis_q;
    assign wbm_cyc_o        = bus;
    assign wbm_stb_o        = bus;
    assign wbm_we_o         = bus & we_q;
    assign wbm_sel_o        = bus ? (we_q ? st_sel : ld_sel) : 4'b0000;
    assign wbm_adr_o        = bus ? {addr_q[31:2], 2'b00} : '0;
    assign wbm_dat_o        = bus && we_q ? st_dat : '0;
endmodule

// File: tb/tb_lsu_wb.sv
// tb_lsu_wb: directed vector table plus hand sequences for timeout, reset and stray acks
module tb_lsu_wb;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_valid_b = 0, req_we = 0, req_uns = 0;
    logic [31:0] req_addr = 0, req_wdata = 0, s_dat = 0;
    logic [1:0]  req_size = 0;
    logic        s_ack = 0, s_err = 0, ack_b = 0, err_b = 0;
    logic        ready, rsp_valid, rsp_err, rsp_mis, cyc, stb, we;
    logic [31:0] rsp_rdata, adr, dat;
    logic [3:0]  sel;
    logic        ready_b, rsp_valid_b, rsp_err_b, rsp_mis_b, cyc_b, stb_b, we_b;
    logic [31:0] rsp_rdata_b, adr_b, dat_b;
    logic [3:0]  sel_b;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    lsu_wb #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_size_i(req_size), .req_unsigned_i(req_uns), .rsp_valid_o(rsp_valid),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err), .rsp_misaligned_o(rsp_mis),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat), .wbm_dat_i(s_dat), .wbm_ack_i(s_ack),
        .wbm_err_i(s_err));

    lsu_wb #(.TIMEOUT_CYCLES(0)) dut_nt (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_b), .req_ready_o(ready_b),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_size_i(req_size), .req_unsigned_i(req_uns), .rsp_valid_o(rsp_valid_b),
        .rsp_rdata_o(rsp_rdata_b), .rsp_err_o(rsp_err_b), .rsp_misaligned_o(rsp_mis_b),
        .wbm_cyc_o(cyc_b), .wbm_stb_o(stb_b), .wbm_we_o(we_b), .wbm_sel_o(sel_b),
        .wbm_adr_o(adr_b), .wbm_dat_o(dat_b), .wbm_dat_i(s_dat), .wbm_ack_i(ack_b),
        .wbm_err_i(err_b));

    typedef struct {
        logic        we;
        logic [31:0] addr, wdata;
        logic [1:0]  size;
        logic        uns;
        int          wt;
        logic        ack, err;
        logic [31:0] sdata;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          nstb;
        logic [31:0] rdata;
        logic        rerr, mis;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic run(input int i);
        vec_t v;
        int nstb = 0, nrsp = 0, at = -1;
        logic [3:0]  s = 0;
        logic [31:0] d = 0, a = 0, rd = 0;
        logic w = 0, e = 0, m = 0, busy_rdy = 0, moved = 0;
        v = vt[i];
        req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_uns = v.uns; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        for (int c = 0; c < 40; c++) begin
            s_ack = 0; s_err = 0;
            if ((stb || rsp_valid) && ready) busy_rdy = 1;
            if (stb) begin
                if (nstb == 0) begin
                    s = sel; d = dat; a = adr; w = we;
                end else if (sel !== s || dat !== d || adr !== a || we !== w) moved = 1;
                nstb++;
                if (nstb == v.wt + 1) begin
                    s_ack = v.ack; s_err = v.err; s_dat = v.sdata;
                end
            end
            if (rsp_valid) begin
                if (nrsp == 0) begin
                    at = c; rd = rsp_rdata; e = rsp_err; m = rsp_mis;
                end
                nrsp++;
            end
            @(negedge clk);
        end
        if (v.nstb > 0) begin
            chk($sformatf("v%0d sel", i), 32'(s), 32'(v.sel));
            chk($sformatf("v%0d dat", i), d, v.dat);
            chk($sformatf("v%0d adr", i), a, {v.addr[31:2], 2'b00});
            chk($sformatf("v%0d we", i), 32'(w), 32'(v.we));
            chk($sformatf("v%0d stable", i), 32'(moved), 0);
        end
        chk($sformatf("v%0d stb_cycles", i), 32'(nstb), 32'(v.nstb));
        chk($sformatf("v%0d rsp_count", i), 32'(nrsp), 1);
        chk($sformatf("v%0d rsp_latency", i), 32'(at), 32'(v.nstb));
        chk($sformatf("v%0d rdata", i), rd, v.rdata);
        chk($sformatf("v%0d err", i), 32'(e), 32'(v.rerr));
        chk($sformatf("v%0d misaligned", i), 32'(m), 32'(v.mis));
        chk($sformatf("v%0d ready_busy", i), 32'(busy_rdy), 0);
        chk($sformatf("v%0d ready_end", i), 32'(ready), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vt[0]  = '{1'b1, 32'h1003, 32'hAB,       2'd0, 1'b0,  2, 1'b1, 1'b0, 32'h0,        4'b1000, 32'hABABABAB, 3, 32'h0,        1'b0, 1'b0};
        vt[1]  = '{1'b0, 32'h2002, 32'h0,        2'd1, 1'b0,  0, 1'b1, 1'b0, 32'h80011234, 4'b1100, 32'h0,        1, 32'hFFFF8001, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 32'h2002, 32'h0,        2'd1, 1'b1,  1, 1'b1, 1'b0, 32'h80011234, 4'b1100, 32'h0,        2, 32'h00008001, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 32'h3001, 32'h0,        2'd2, 1'b0,  0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1'b0, 1'b1};
        vt[4]  = '{1'b0, 32'h4000, 32'h0,        2'd3, 1'b0,  0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1'b0, 1'b1};
        vt[5]  = '{1'b1, 32'h5000, 32'hDEADBEEF, 2'd2, 1'b0,  0, 1'b1, 1'b1, 32'h0,        4'b1111, 32'hDEADBEEF, 1, 32'h0,        1'b1, 1'b0};
        vt[6]  = '{1'b0, 32'h6001, 32'h0,        2'd0, 1'b0,  0, 1'b1, 1'b0, 32'h123480FF, 4'b0010, 32'h0,        1, 32'hFFFFFF80, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 32'h6003, 32'h0,        2'd0, 1'b1,  0, 1'b1, 1'b0, 32'hC0112233, 4'b1000, 32'h0,        1, 32'h000000C0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 32'h7002, 32'h0000BEEF, 2'd1, 1'b0,  1, 1'b1, 1'b0, 32'h0,        4'b1100, 32'hBEEFBEEF, 2, 32'h0,        1'b0, 1'b0};
        vt[9]  = '{1'b0, 32'h8000, 32'h0,        2'd2, 1'b0,  0, 1'b1, 1'b0, 32'h89ABCDEF, 4'b1111, 32'h0,        1, 32'h89ABCDEF, 1'b0, 1'b0};
        vt[10] = '{1'b0, 32'h9000, 32'h0,        2'd2, 1'b0, 99, 1'b0, 1'b0, 32'h0,        4'b1111, 32'h0,        8, 32'h0,        1'b1, 1'b0};
        vt[11] = '{1'b0, 32'hA000, 32'h0,        2'd2, 1'b0,  1, 1'b0, 1'b1, 32'h55,       4'b1111, 32'h0,        2, 32'h0,        1'b1, 1'b0};
        vt[12] = '{1'b0, 32'h2001, 32'h0,        2'd1, 1'b0,  0, 1'b1, 1'b0, 32'h0,        4'b0000, 32'h0,        0, 32'h0,        1'b0, 1'b1};
        vt[13] = '{1'b1, 32'hB001, 32'h12345678, 2'd0, 1'b0,  0, 1'b1, 1'b0, 32'h0,        4'b0010, 32'h78787878, 1, 32'h0,        1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst ready", 32'(ready), 1);
        chk("rst cyc_stb", 32'({cyc, stb, we}), 0);
        chk("rst sel", 32'(sel), 0);
        chk("rst adr", adr, 0);
        chk("rst dat", dat, 0);
        chk("rst rsp", 32'({rsp_valid, rsp_err, rsp_mis}), 0);
        chk("rst rdata", rsp_rdata, 0);
        rst = 0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) run(i);

        // stray ack/err while idle must not produce a response
        n = 0;
        s_ack = 1; s_err = 1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || stb) n++;
        end
        s_ack = 0; s_err = 0;
        chk("idle_ack rsp", 32'(n), 0);
        chk("idle_ack ready", 32'(ready), 1);

        // timeout disabled: strobe stays up indefinitely
        req_we = 0; req_addr = 32'hC000; req_size = 2'd2; req_uns = 0; req_valid_b = 1;
        @(negedge clk);
        req_valid_b = 0;
        n = 0;
        begin
            int r = 0;
            repeat (1000) begin
                if (stb_b) n++;
                if (rsp_valid_b) r++;
                @(negedge clk);
            end
            chk("no_timeout stb_cycles", 32'(n), 1000);
            chk("no_timeout rsp", 32'(r), 0);
        end
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("no_timeout rst cyc_stb", 32'({cyc_b, stb_b}), 0);
        chk("no_timeout rst ready", 32'(ready_b), 1);

        // reset in the middle of a bus cycle
        req_we = 0; req_addr = 32'hD000; req_size = 2'd2; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        chk("midrst stb_before", 32'(stb), 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst cyc_stb", 32'({cyc, stb}), 0);
        n = 0;
        repeat (10) begin
            if (rsp_valid) n++;
            @(negedge clk);
        end
        chk("midrst rsp", 32'(n), 0);
        run(9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
